// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if: one AHB-lite master/slave link
interface ahb_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;
  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave  (input HADDR, HTRANS, HWRITE, HSIZE, HWDATA, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-lite path between two masters with one-deep address buffers
module ahb_master_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ahb_master_arbiter_if.slave  m0,
  ahb_master_arbiter_if.slave  m1,
  ahb_master_arbiter_if.master bus,
  output logic [1:0]           D_OWNER
);
  logic [1:0] req, dsel, comp, rdy, acc, pend_q, pend_d, outst_q, outst_d, wr_in, wr_q;
  logic [AW-1:0] addr_in [2];
  logic [AW-1:0] addr_q [2];
  logic [2:0] size_in [2];
  logic [2:0] size_q [2];
  logic [DW-1:0] wdata;
  logic a_vld_q, a_vld_d, a_own_q, a_own_d, d_vld_q, d_vld_d, d_own_q, d_own_d, rr_q, rr_d, win, upd;
  logic unused_ok;
  assign unused_ok = ^{m0.HTRANS[0], m1.HTRANS[0]};
  assign req = {m1.HTRANS[1], m0.HTRANS[1]};
  assign wr_in = {m1.HWRITE, m0.HWRITE};
  assign addr_in[0] = m0.HADDR;
  assign addr_in[1] = m1.HADDR;
  assign size_in[0] = m0.HSIZE;
  assign size_in[1] = m1.HSIZE;
  always_comb begin
    dsel = {d_vld_q & d_own_q, d_vld_q & ~d_own_q};
    comp = dsel & {2{bus.HREADY}};
    rdy = ~outst_q | comp;
    acc = req & rdy;
    outst_d = acc | (outst_q & ~comp);
    pend_d = (pend_q & ~((bus.HREADY & a_vld_q) ? (2'b01 << a_own_q) : 2'b00)) | acc;
    upd = bus.HREADY | ~a_vld_q;
    win = &pend_d ? (FIXED_PRIO ? 1'b0 : ~rr_q) : pend_d[1];
    a_vld_d = upd ? |pend_d : a_vld_q;
    a_own_d = (upd & |pend_d) ? win : a_own_q;
    rr_d = (upd & |pend_d) ? win : rr_q;
    d_vld_d = bus.HREADY ? a_vld_q : d_vld_q;
    d_own_d = bus.HREADY ? a_own_q : d_own_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      outst_q <= '0;
      wr_q <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      size_q[0] <= '0;
      size_q[1] <= '0;
      a_vld_q <= 1'b0;
      a_own_q <= 1'b0;
      d_vld_q <= 1'b0;
      d_own_q <= 1'b0;
      rr_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
      outst_q <= outst_d;
      a_vld_q <= a_vld_d;
      a_own_q <= a_own_d;
      d_vld_q <= d_vld_d;
      d_own_q <= d_own_d;
      rr_q <= rr_d;
      for (int i = 0; i < 2; i++)
        if (acc[i]) begin
          addr_q[i] <= addr_in[i];
          wr_q[i] <= wr_in[i];
          size_q[i] <= size_in[i];
        end
    end
  end
  assign wdata = d_own_q ? m1.HWDATA : m0.HWDATA;
  assign bus.HTRANS = {a_vld_q, 1'b0};
  assign bus.HADDR = a_vld_q ? addr_q[a_own_q] : '0;
  assign bus.HWRITE = a_vld_q & wr_q[a_own_q];
  assign bus.HSIZE = a_vld_q ? size_q[a_own_q] : '0;
  assign bus.HWDATA = wdata;
  assign m0.HRDATA = bus.HRDATA;
  assign m1.HRDATA = bus.HRDATA;
  assign m0.HREADY = rdy[0];
  assign m1.HREADY = rdy[1];
  assign m0.HRESP = bus.HRESP & dsel[0];
  assign m1.HRESP = bus.HRESP & dsel[1];
  assign D_OWNER = {d_vld_q, d_own_q};
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed and random checks of round-robin and fixed-priority instances
module tb_ahb_master_arbiter;
  logic clk, rst;
  logic hready, hresp;
  logic [31:0] hrdata;
  logic [1:0]  m_htrans [2];
  logic [31:0] m_haddr [2];
  logic [31:0] m_hwdata [2];
  logic        m_hwrite [2];
  logic [2:0]  m_hsize [2];
  int n_tests = 0, n_fail = 0;
  ahb_master_arbiter_if m0a(), m1a(), busa(), m0b(), m1b(), busb();
  logic [1:0] downer_a, downer_b;
  ahb_master_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .bus(busa), .D_OWNER(downer_a));
  ahb_master_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .bus(busb), .D_OWNER(downer_b));
  assign m0a.HTRANS = m_htrans[0]; assign m0b.HTRANS = m_htrans[0];
  assign m1a.HTRANS = m_htrans[1]; assign m1b.HTRANS = m_htrans[1];
  assign m0a.HADDR = m_haddr[0];   assign m0b.HADDR = m_haddr[0];
  assign m1a.HADDR = m_haddr[1];   assign m1b.HADDR = m_haddr[1];
  assign m0a.HWRITE = m_hwrite[0]; assign m0b.HWRITE = m_hwrite[0];
  assign m1a.HWRITE = m_hwrite[1]; assign m1b.HWRITE = m_hwrite[1];
  assign m0a.HSIZE = m_hsize[0];   assign m0b.HSIZE = m_hsize[0];
  assign m1a.HSIZE = m_hsize[1];   assign m1b.HSIZE = m_hsize[1];
  assign m0a.HWDATA = m_hwdata[0]; assign m0b.HWDATA = m_hwdata[0];
  assign m1a.HWDATA = m_hwdata[1]; assign m1b.HWDATA = m_hwdata[1];
  assign busa.HREADY = hready; assign busb.HREADY = hready;
  assign busa.HRESP = hresp;   assign busb.HRESP = hresp;
  assign busa.HRDATA = hrdata; assign busb.HRDATA = hrdata;
  logic [1:0]  o_htrans [2];
  logic [31:0] o_haddr [2];
  logic [31:0] o_hwdata [2];
  logic        o_hwrite [2];
  logic [2:0]  o_hsize [2];
  logic [1:0]  o_rdy [2];
  logic [1:0]  o_resp [2];
  logic [1:0]  o_downer [2];
  logic [31:0] o_rdata [2][2];
  assign o_htrans[0] = busa.HTRANS; assign o_htrans[1] = busb.HTRANS;
  assign o_haddr[0] = busa.HADDR;   assign o_haddr[1] = busb.HADDR;
  assign o_hwdata[0] = busa.HWDATA; assign o_hwdata[1] = busb.HWDATA;
  assign o_hwrite[0] = busa.HWRITE; assign o_hwrite[1] = busb.HWRITE;
  assign o_hsize[0] = busa.HSIZE;   assign o_hsize[1] = busb.HSIZE;
  assign o_rdy[0] = {m1a.HREADY, m0a.HREADY};
  assign o_rdy[1] = {m1b.HREADY, m0b.HREADY};
  assign o_resp[0] = {m1a.HRESP, m0a.HRESP};
  assign o_resp[1] = {m1b.HRESP, m0b.HRESP};
  assign o_downer[0] = downer_a;    assign o_downer[1] = downer_b;
  assign o_rdata[0][0] = m0a.HRDATA; assign o_rdata[0][1] = m1a.HRDATA;
  assign o_rdata[1][0] = m0b.HRDATA; assign o_rdata[1][1] = m1b.HRDATA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model per instance (0 = round-robin, 1 = fixed priority).
  // Bus slots hold the owning master number, or -1 when empty.
  int aown [2];
  int down [2];
  int last [2];
  bit pend [2][2];
  bit outst [2][2];
  logic [31:0] paddr [2][2];
  logic        pwr [2][2];
  logic [2:0]  psz [2][2];

  task automatic model_step(input int k);
    bit r [2];
    int old;
    if (rst) begin
      aown[k] = -1; down[k] = -1; last[k] = 1;
      for (int x = 0; x < 2; x++) begin pend[k][x] = 0; outst[k][x] = 0; end
      return;
    end
    old = aown[k];
    for (int x = 0; x < 2; x++) r[x] = !outst[k][x] || (down[k] == x && hready);
    for (int x = 0; x < 2; x++) if (down[k] == x && hready) outst[k][x] = 0;
    if (hready) begin
      if (old >= 0) pend[k][old] = 0;
      down[k] = old;
    end
    for (int x = 0; x < 2; x++)
      if (m_htrans[x][1] && r[x]) begin
        pend[k][x] = 1; outst[k][x] = 1;
        paddr[k][x] = m_haddr[x]; pwr[k][x] = m_hwrite[x]; psz[k][x] = m_hsize[x];
      end
    if (hready || old < 0) begin
      if (pend[k][0] && pend[k][1]) aown[k] = (k == 1) ? 0 : 1 - last[k];
      else if (pend[k][0]) aown[k] = 0;
      else if (pend[k][1]) aown[k] = 1;
      else aown[k] = -1;
      if (aown[k] >= 0) last[k] = aown[k];
    end
  endtask

  always @(posedge clk or posedge rst) for (int k = 0; k < 2; k++) model_step(k);

  always @(negedge clk) if (rst === 1'b0) for (int k = 0; k < 2; k++) begin
    int a, d;
    a = aown[k];
    d = down[k];
    chk($sformatf("u%0d.htrans", k), 32'(o_htrans[k]), a >= 0 ? 32'd2 : 32'd0);
    if (a >= 0) begin
      chk($sformatf("u%0d.haddr", k), o_haddr[k], paddr[k][a]);
      chk($sformatf("u%0d.hwrite", k), 32'(o_hwrite[k]), 32'(pwr[k][a]));
      chk($sformatf("u%0d.hsize", k), 32'(o_hsize[k]), 32'(psz[k][a]));
    end else
      chk($sformatf("u%0d.haddr_idle", k), o_haddr[k], 32'd0);
    for (int x = 0; x < 2; x++) begin
      chk($sformatf("u%0d.m%0d_hready", k, x), 32'(o_rdy[k][x]), 32'(!outst[k][x] || (d == x && hready)));
      chk($sformatf("u%0d.m%0d_hresp", k, x), 32'(o_resp[k][x]), 32'(hresp && d == x));
      chk($sformatf("u%0d.m%0d_hrdata", k, x), o_rdata[k][x], hrdata);
    end
    chk($sformatf("u%0d.d_vld", k), 32'(o_downer[k][1]), 32'(d >= 0));
    if (d >= 0) begin
      chk($sformatf("u%0d.d_own", k), 32'(o_downer[k][0]), 32'(d));
      chk($sformatf("u%0d.hwdata", k), o_hwdata[k], m_hwdata[d]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int x, input logic [31:0] a, input logic w);
    m_htrans[x] = 2'b10; m_haddr[x] = a; m_hwrite[x] = w; m_hsize[x] = 3'b010;
  endtask

  task automatic idle();
    m_htrans[0] = 2'b00; m_htrans[1] = 2'b00;
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.u%0d.htrans", tag, k), 32'(o_htrans[k]), 32'd0);
      chk($sformatf("%s.u%0d.haddr", tag, k), o_haddr[k], 32'd0);
      chk($sformatf("%s.u%0d.hready", tag, k), 32'(o_rdy[k]), 32'd3);
      chk($sformatf("%s.u%0d.resp", tag, k), 32'(o_resp[k]), 32'd0);
      chk($sformatf("%s.u%0d.downer", tag, k), 32'(o_downer[k]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    for (int x = 0; x < 2; x++) begin
      m_haddr[x] = '0; m_hwdata[x] = '0; m_hwrite[x] = 1'b0; m_hsize[x] = '0;
    end
    idle();
    #2;
    chk_reset("reset");
    cyc(); cyc();
    rst = 1'b0;
    // simultaneous writes: M0 first, then M1, consecutive data phases; HRESP on M1 data phase
    req(0, 32'h8000_0008, 1'b1); req(1, 32'h8001_0000, 1'b1);
    @(negedge clk);
    chk("wr.accept", 32'(o_rdy[0]), 32'd3);
    cyc();
    idle(); m_hwdata[0] = 32'h1111_1111; m_hwdata[1] = 32'h2222_2222;
    @(negedge clk);
    chk("wr.a0_htrans", 32'(o_htrans[0]), 32'd2);
    chk("wr.a0_haddr", o_haddr[0], 32'h8000_0008);
    chk("wr.a0_hwrite", 32'(o_hwrite[0]), 32'd1);
    chk("wr.a0_rdy", 32'(o_rdy[0]), 32'd0);
    cyc();
    @(negedge clk);
    chk("wr.a1_haddr", o_haddr[0], 32'h8001_0000);
    chk("wr.d0_hwdata", o_hwdata[0], 32'h1111_1111);
    chk("wr.d0_owner", 32'(o_downer[0]), 32'd2);
    chk("wr.d0_rdy", 32'(o_rdy[0]), 32'd1);
    cyc();
    hresp = 1'b1;
    @(negedge clk);
    chk("wr.d1_hwdata", o_hwdata[0], 32'h2222_2222);
    chk("wr.d1_owner", 32'(o_downer[0]), 32'd3);
    chk("wr.d1_htrans", 32'(o_htrans[0]), 32'd0);
    chk("wr.d1_rdy", 32'(o_rdy[0]), 32'd3);
    chk("wr.d1_resp", 32'(o_resp[0]), 32'd2);
    cyc();
    hresp = 1'b0;
    // single M0 read with a zero-wait slave
    req(0, 32'h1000_0004, 1'b0);
    @(negedge clk);
    chk("rd.accept", 32'(o_rdy[0][0]), 32'd1);
    cyc();
    idle();
    @(negedge clk);
    chk("rd.htrans", 32'(o_htrans[0]), 32'd2);
    chk("rd.haddr", o_haddr[0], 32'h1000_0004);
    chk("rd.hwrite", 32'(o_hwrite[0]), 32'd0);
    chk("rd.wait", 32'(o_rdy[0]), 32'd2);
    cyc();
    hrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd.done", 32'(o_rdy[0]), 32'd3);
    chk("rd.hrdata", o_rdata[0][0], 32'hDEAD_BEEF);
    chk("rd.idle", 32'(o_htrans[0]), 32'd0);
    // slave wait states hold the pending M1 address stable
    cyc();
    req(0, 32'h0000_0100, 1'b0);
    cyc();
    idle(); req(1, 32'h0000_0200, 1'b0);
    @(negedge clk);
    chk("hold.m0_addr", o_haddr[0], 32'h0000_0100);
    chk("hold.m1_rdy", 32'(o_rdy[0][1]), 32'd1);
    cyc();
    idle(); hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold.w%0d_htrans", i), 32'(o_htrans[0]), 32'd2);
      chk($sformatf("hold.w%0d_haddr", i), o_haddr[0], 32'h0000_0200);
      chk($sformatf("hold.w%0d_owner", i), 32'(o_downer[0]), 32'd2);
      cyc();
    end
    hready = 1'b1;
    @(negedge clk);
    chk("hold.rel_haddr", o_haddr[0], 32'h0000_0200);
    cyc();
    @(negedge clk);
    chk("hold.m1_data", 32'(o_downer[0]), 32'd3);
    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      hready = ($urandom_range(0, 3) != 0);
      hresp = ($urandom_range(0, 7) == 0);
      hrdata = $urandom;
      for (int x = 0; x < 2; x++) begin
        m_htrans[x] = 2'($urandom_range(0, 3));
        m_haddr[x] = $urandom;
        m_hwrite[x] = 1'($urandom_range(0, 1));
        m_hsize[x] = 3'($urandom_range(0, 7));
        m_hwdata[x] = $urandom;
      end
    end
    cyc();
    hready = 1'b1; hresp = 1'b0; idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    // M0 streams, M1 asks once: both instances give M1 the next slot
    req(0, 32'h0000_0300, 1'b0); req(1, 32'h0000_0400, 1'b0);
    cyc();
    m_htrans[1] = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("starve.u%0d_m0", k), o_haddr[k], 32'h0000_0300);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("starve.u%0d_m1", k), o_haddr[k], 32'h0000_0400);
    cyc();
    idle();
    cyc(); cyc(); cyc();
    // reset with both phases busy
    req(0, 32'h0000_0500, 1'b0); req(1, 32'h0000_0600, 1'b0);
    cyc();
    idle();
    cyc();
    #1;
    chk("rstmid.busy", 32'({o_htrans[0][1], o_downer[0][1]}), 32'd3);
    rst = 1'b1;
    #1;
    chk_reset("rstmid");
    cyc();
    rst = 1'b0;
    req(1, 32'h0000_0700, 1'b1);
    cyc();
    idle();
    @(negedge clk);
    chk("rstmid.m1_htrans", 32'(o_htrans[0]), 32'd2);
    chk("rstmid.m1_haddr", o_haddr[0], 32'h0000_0700);
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
